// File: rtl/div_seq_pkg.sv
// Shared types and default sizing for the multi-cycle DIV/DIVU sequencer.
package div_seq_pkg;

  localparam int DIV_DW    = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_seq_if.sv
// Execute-stage <-> divide-sequencer handshake: operands/start/annul in, {rem, quo}/ready out.
interface div_seq_if
  import div_seq_pkg::*;
#(
  parameter int DW = DIV_DW
);
  logic            signed_div_i;
  logic [DW-1:0]   opdata1_i;
  logic [DW-1:0]   opdata2_i;
  logic            start_i;
  logic            annul_i;
  logic [2*DW-1:0] result_o;
  logic            ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_seq.sv
// Restoring shift-subtract divider for DIV/DIVU: one quotient bit per clock,
// result {remainder, quotient} held until the execute stage drops start.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DW    = DIV_DW,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  div_seq_if.slave    bus
);

  div_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*DW:0]   work_q, work_d;
  logic [DW-1:0]   divisor_q, divisor_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [2*DW-1:0] result_q, result_d;
  logic            ready_q, ready_d;
  logic [DW:0]     tmp;

  function automatic logic [DW-1:0] magnitude(input logic [DW-1:0] v, input logic sgn);
    return (sgn && v[DW-1]) ? -v : v;
  endfunction

  function automatic logic [DW-1:0] cond_neg(input logic [DW-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Trial subtraction of the divisor from the upper half of the work register.
  assign tmp = {1'b0, work_q[2*DW-1:DW]} - {1'b0, divisor_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;

    unique case (state_q)
      DIV_FREE: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (bus.start_i && !bus.annul_i) begin
          divisor_d = magnitude(bus.opdata2_i, bus.signed_div_i);
          neg_quo_d = bus.signed_div_i && (bus.opdata1_i[DW-1] ^ bus.opdata2_i[DW-1]);
          neg_rem_d = bus.signed_div_i && bus.opdata1_i[DW-1];
          cnt_d     = '0;
          // Dividend enters one bit up so the first trial sees its MSB; the
          // 2*DW+1 register then yields the remainder in [2*DW:DW+1] after DW steps.
          work_d    = {{DW{1'b0}}, magnitude(bus.opdata1_i, bus.signed_div_i), 1'b0};
          state_d   = (bus.opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
        end
      end

      DIV_BYZERO: begin
        result_d = '0;
        if (bus.annul_i) begin
          state_d = DIV_FREE;
          ready_d = 1'b0;
        end else begin
          state_d = DIV_END;
          ready_d = 1'b1;
        end
      end

      DIV_ON: begin
        if (bus.annul_i) begin
          state_d  = DIV_FREE;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q != CNT_W'(DW)) begin
          if (tmp[DW]) begin
            work_d = {work_q[2*DW-1:0], 1'b0};
          end else begin
            work_d = {tmp[DW-1:0], work_q[DW-1:0], 1'b1};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d  = DIV_END;
          result_d = {cond_neg(work_q[2*DW:DW+1], neg_rem_q),
                      cond_neg(work_q[DW-1:0], neg_quo_q)};
          ready_d  = 1'b1;
        end
      end

      DIV_END: begin
        if (!bus.start_i || bus.annul_i) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end

      default: begin
        state_d = DIV_FREE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: directed divisions push expected {rem, quo} and
// completion cycle; a negedge monitor pops and compares on each ready_o rise.
module tb_div_seq;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  div_seq_if #(.DW(32)) bus ();

  div_seq #(.DW(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [63:0] exp_q[$];
  int          cyc_q[$];
  string       name_q[$];
  logic [63:0] cur_exp;
  string       cur_name;
  logic        rdy_prev;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compare each newly valid result, and that a held result stays put.
  initial begin
    rdy_prev = 1'b0;
    cur_exp  = '0;
    cur_name = "none";
  end

  always @(negedge clk) begin
    int c;
    if (bus.ready_o && !rdy_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got result %h with no division outstanding", bus.result_o);
      end else begin
        cur_exp  = exp_q.pop_front();
        cur_name = name_q.pop_front();
        c        = cyc_q.pop_front();
        chk({cur_name, "_result"}, bus.result_o, cur_exp);
        chk({cur_name, "_ready_cycle"}, 64'(cyc), 64'(c));
      end
    end else if (bus.ready_o && rdy_prev) begin
      chk({cur_name, "_held"}, bus.result_o, cur_exp);
    end
    rdy_prev = bus.ready_o;
  end

  task automatic push_exp(input logic [63:0] exp, input int lat, input string nm);
    exp_q.push_back(exp);
    cyc_q.push_back(cyc + 1 + lat);
    name_q.push_back(nm);
  endtask

  task automatic wait_ready(input string nm, output bit ok);
    int n;
    n = 0;
    while (!bus.ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = bus.ready_o;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: ready_o still 0 after %0d cycles, required 1", nm, n);
    end
  endtask

  // Issue one division; hold=1 keeps start_i high until the result is seen.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat, input bit hold, input string nm);
    bit ok;
    @(posedge clk); #1;
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    push_exp(exp, lat, nm);
    @(posedge clk); #1;
    bus.opdata1_i    = 32'hDEAD_BEEF;
    bus.opdata2_i    = 32'h0000_0000;
    bus.signed_div_i = ~sgn;
    if (!hold) bus.start_i = 1'b0;
    wait_ready(nm, ok);
    if (ok) begin
      if (hold) begin
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        @(negedge clk);
        chk({nm, "_ready_held"}, 64'(bus.ready_o), 64'd1);
      end
      @(negedge clk);
      chk({nm, "_ready_drop"}, 64'(bus.ready_o), 64'd0);
      chk({nm, "_result_clear"}, bus.result_o, 64'd0);
    end
  endtask

  initial begin
    bit ok;
    int seen;
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;

    // Async reset before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("reset_ready", 64'(bus.ready_o), 64'd0);
    chk("reset_result", bus.result_o, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    do_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1'b1, "divu_100_7");
    do_div(1'b1, 32'hFFFFFFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD, 33, 1'b1, "div_m7_2");
    do_div(1'b1, 32'h7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 1'b1, "div_7_m2");
    do_div(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 33, 1'b1, "div_m7_m2");
    do_div(1'b0, 32'hFFFFFFF9, 32'h2, 64'h00000001_7FFFFFFC, 33, 1'b1, "divu_big_2");
    do_div(1'b0, 32'd5, 32'd0, 64'h0, 1, 1'b1, "divu_byzero");
    do_div(1'b1, 32'hFFFFFFF9, 32'd0, 64'h0, 1, 1'b1, "div_byzero");
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 1'b1, "div_min_m1");
    do_div(1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 33, 1'b1, "divu_max_1");
    do_div(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 33, 1'b1, "divu_max_max");
    do_div(1'b0, 32'd7, 32'd100, 64'h00000007_00000000, 33, 1'b0, "divu_7_100_nohold");

    // Annul at iteration 10: no result ever, then a fresh division right after.
    @(posedge clk); #1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ready_o) seen++;
    end
    chk("annul_no_ready", 64'(seen), 64'd0);
    do_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 1'b1, "divu_9_3_after_annul");

    // Reset between edges while a division is iterating.
    @(posedge clk); #1;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_on_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_on_result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1'b1, "divu_after_rst");

    // Reset between edges while a result is being held.
    @(posedge clk); #1;
    bus.signed_div_i = 1'b1;
    bus.opdata1_i    = 32'hFFFFFFF9;
    bus.opdata2_i    = 32'h2;
    bus.start_i      = 1'b1;
    push_exp(64'hFFFFFFFF_FFFFFFFD, 33, "div_before_end_rst");
    @(posedge clk); #1;
    wait_ready("div_before_end_rst", ok);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("rst_end_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_end_result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_div(1'b1, 32'h7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 1'b0, "div_after_end_rst");

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
